fpu_bus_slave: RTL and testbench

- Host-facing register interface of the FPU. It is the responder to the 8-bit CPU bus: it decodes cs/rd/wr/addr, holds operand A, operand B and the opcode, and issues a start pulse to the FPU core.
- It captures the core result and drives the cmd_end/end_ack completion handshake and busy.
- It sits between the Sol-1 CPU bus and the FPU datapath/sequencer.

---
 rtl/pa_fpu.sv | 39 +++
 rtl/fpu_bus_strobe.sv | 19 +
 rtl/fpu_bus_slave.sv | 112 +++++++++++
 tb/tb_fpu_bus_slave.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_fpu.sv
// Shared definitions for the FPU host register interface: register map, opcodes, bus FSM states.
package pa_fpu;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 4;
  localparam int unsigned OPW = 32;

  localparam logic [3:0] ADDR_A0     = 4'h0;
  localparam logic [3:0] ADDR_A1     = 4'h1;
  localparam logic [3:0] ADDR_A2     = 4'h2;
  localparam logic [3:0] ADDR_A3     = 4'h3;
  localparam logic [3:0] ADDR_B0     = 4'h4;
  localparam logic [3:0] ADDR_B1     = 4'h5;
  localparam logic [3:0] ADDR_B2     = 4'h6;
  localparam logic [3:0] ADDR_B3     = 4'h7;
  localparam logic [3:0] ADDR_OP     = 4'h8;
  localparam logic [3:0] ADDR_START  = 4'h9;
  localparam logic [3:0] ADDR_R0     = 4'h9;
  localparam logic [3:0] ADDR_R1     = 4'hA;
  localparam logic [3:0] ADDR_R2     = 4'hB;
  localparam logic [3:0] ADDR_R3     = 4'hC;
  localparam logic [3:0] ADDR_STATUS = 4'hD;

  typedef enum logic [7:0] {
    OP_ADD  = 8'h00,
    OP_SUB  = 8'h01,
    OP_MUL  = 8'h02,
    OP_DIV  = 8'h03,
    OP_SQRT = 8'h04,
    OP_LOG2 = 8'h05,
    OP_EXP2 = 8'h06
  } e_fpu_op;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } e_bus_state;

endpackage

// File: rtl/fpu_bus_strobe.sv
// Samples an active-low bus strobe and flags the first cycle it is seen low while selected.
module fpu_bus_strobe (
  input  logic clk,
  input  logic arst,
  input  logic cs,
  input  logic strobe,
  output logic pulse_c
);

  logic strobe_q;

  always_ff @(posedge clk) begin
    if (arst) strobe_q <= 1'b0;
    else      strobe_q <= strobe;
  end

  assign pulse_c = !cs && !strobe && strobe_q;

endmodule

// File: rtl/fpu_bus_slave.sv
// Host register interface of the FPU: operand/opcode registers, start/completion handshake, read mux.
module fpu_bus_slave
  import pa_fpu::*;
#(
  parameter int unsigned DW  = 8,
  parameter int unsigned AW  = 4,
  parameter int unsigned OPW = 32
) (
  input  logic           clk,
  input  logic           arst,
  input  logic [DW-1:0]  databus_in,
  output logic [DW-1:0]  databus_out,
  input  logic [AW-1:0]  addr,
  input  logic           cs,
  input  logic           rd,
  input  logic           wr,
  input  logic           end_ack,
  output logic           cmd_end,
  output logic           busy,
  output logic [OPW-1:0] core_op_a,
  output logic [OPW-1:0] core_op_b,
  output logic [7:0]     core_op,
  output logic           core_start,
  input  logic           core_done,
  input  logic [OPW-1:0] core_result
);

  e_bus_state     state;
  logic [OPW-1:0] op_a;
  logic [OPW-1:0] op_b;
  logic [7:0]     op_code;
  logic [OPW-1:0] result;
  logic           we_c;
  logic           wr_reg_c;
  logic           start_c;
  logic [DW-1:0]  rd_data_c;
  logic [1:0]     res_idx_c;

  fpu_bus_strobe u_wr_strobe (
    .clk     (clk),
    .arst    (arst),
    .cs      (cs),
    .strobe  (wr),
    .pulse_c (we_c)
  );

  // Register writes are frozen while an operation is in flight
  assign wr_reg_c = we_c && (addr <= AW'(ADDR_OP)) && !busy;
  assign start_c  = we_c && (addr == AW'(ADDR_START)) && (state == IDLE);

  assign core_op_a = op_a;
  assign core_op_b = op_b;
  assign core_op   = op_code;

  always_comb begin
    rd_data_c = '0;
    res_idx_c = 2'(addr - AW'(ADDR_R0));
    if (addr <= AW'(ADDR_A3))          rd_data_c = op_a[addr[1:0]*DW +: DW];
    else if (addr <= AW'(ADDR_B3))     rd_data_c = op_b[addr[1:0]*DW +: DW];
    else if (addr == AW'(ADDR_OP))     rd_data_c = DW'(op_code);
    else if (addr <= AW'(ADDR_R3))     rd_data_c = result[res_idx_c*DW +: DW];
    else if (addr == AW'(ADDR_STATUS)) rd_data_c = DW'({busy, cmd_end});
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      cmd_end     <= 1'b0;
      core_start  <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      op_code     <= '0;
      result      <= '0;
      databus_out <= '0;
    end else begin
      core_start  <= 1'b0;
      databus_out <= (!cs && !rd) ? rd_data_c : '0;

      if (wr_reg_c) begin
        if (addr <= AW'(ADDR_A3))      op_a[addr[1:0]*DW +: DW] <= databus_in;
        else if (addr <= AW'(ADDR_B3)) op_b[addr[1:0]*DW +: DW] <= databus_in;
        else                           op_code <= 8'(databus_in);
      end

      // A completion coinciding with end_ack keeps cmd_end set
      case (state)
        IDLE: begin
          if (start_c) begin
            state      <= RUN;
            core_start <= 1'b1;
            busy       <= 1'b1;
            cmd_end    <= 1'b0;
          end else if (end_ack) begin
            cmd_end <= 1'b0;
          end
        end
        RUN: begin
          if (core_done) begin
            result  <= core_result;
            cmd_end <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (end_ack) begin
            cmd_end <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_bus_slave.sv
// Self-checking bench for fpu_bus_slave against a byte-level register-map model.
module tb_fpu_bus_slave;
  import pa_fpu::*;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [7:0]  databus_in = 8'h00;
  logic [7:0]  databus_out;
  logic [3:0]  addr = 4'h0;
  logic        cs = 1'b1;
  logic        rd = 1'b1;
  logic        wr = 1'b1;
  logic        end_ack = 1'b0;
  logic        cmd_end;
  logic        busy;
  logic [31:0] core_op_a;
  logic [31:0] core_op_b;
  logic [7:0]  core_op;
  logic        core_start;
  logic        core_done = 1'b0;
  logic [31:0] core_result = 32'h0;

  int checks = 0;
  int failures = 0;
  int start_cycles = 0;

  // Expected register contents, one byte per entry
  logic [7:0] m_a [4];
  logic [7:0] m_b [4];
  logic [7:0] m_res [4];
  logic [7:0] m_op;
  bit         m_busy;
  bit         m_cmd_end;

  fpu_bus_slave dut (
    .clk         (clk),
    .arst        (arst),
    .databus_in  (databus_in),
    .databus_out (databus_out),
    .addr        (addr),
    .cs          (cs),
    .rd          (rd),
    .wr          (wr),
    .end_ack     (end_ack),
    .cmd_end     (cmd_end),
    .busy        (busy),
    .core_op_a   (core_op_a),
    .core_op_b   (core_op_b),
    .core_op     (core_op),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_result (core_result)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (core_start === 1'b1) start_cycles++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] m_read(input int a);
    if (a < 4)       return m_a[a];
    else if (a < 8)  return m_b[a-4];
    else if (a == 8) return m_op;
    else if (a < 13) return m_res[a-9];
    else if (a == 13) return {6'b0, m_busy, m_cmd_end};
    return 8'h00;
  endfunction

  function automatic logic [31:0] m_word(input logic [7:0] b [4]);
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_a[i] = 8'h00; m_b[i] = 8'h00; m_res[i] = 8'h00;
    end
    m_op = 8'h00; m_busy = 0; m_cmd_end = 0;
  endtask

  task automatic bus_write(input int a, input logic [7:0] d);
    @(negedge clk); cs = 1'b0; wr = 1'b0; addr = 4'(a); databus_in = d;
    @(negedge clk); wr = 1'b1; cs = 1'b1;
    if (!m_busy) begin
      if (a < 4)       m_a[a] = d;
      else if (a < 8)  m_b[a-4] = d;
      else if (a == 8) m_op = d;
      else if (a == 9) begin m_busy = 1; m_cmd_end = 0; end
    end
  endtask

  task automatic bus_read(input int a, output logic [7:0] d);
    @(negedge clk); cs = 1'b0; rd = 1'b0; addr = 4'(a);
    @(negedge clk); d = databus_out; cs = 1'b1; rd = 1'b1;
  endtask

  task automatic write_operands(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
    for (int i = 0; i < 4; i++) bus_write(i, a[8*i +: 8]);
    for (int i = 0; i < 4; i++) bus_write(4 + i, b[8*i +: 8]);
    bus_write(8, op);
  endtask

  // Start an op, optionally poke registers while running, then complete it after lat cycles
  task automatic run_op(input logic [31:0] res, input int lat, input bit poke, input bit ack_with_done);
    int s0;
    s0 = start_cycles;
    bus_write(9, 8'($urandom));
    checks++;
    if (core_start !== 1'b1 || busy !== 1'b1 || cmd_end !== 1'b0) begin
      failures++;
      $display("FAIL start_issue: core_start=%b busy=%b cmd_end=%b required 1 1 0", core_start, busy, cmd_end);
    end
    checks++;
    if (core_op_a !== m_word(m_a) || core_op_b !== m_word(m_b) || core_op !== m_op) begin
      failures++;
      $display("FAIL core_operands: a=%h b=%h op=%h required %h %h %h",
               core_op_a, core_op_b, core_op, m_word(m_a), m_word(m_b), m_op);
    end
    if (poke) begin
      bus_write(0, 8'hFF);
      bus_write(9, 8'h00);
    end
    repeat (lat) @(negedge clk);
    checks++;
    if (start_cycles - s0 !== 1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL run_phase: start_cycles=%0d busy=%b required 1 1", start_cycles - s0, busy);
    end
    core_done = 1'b1; core_result = res; end_ack = ack_with_done;
    @(negedge clk);
    core_done = 1'b0; end_ack = 1'b0; core_result = $urandom;
    for (int i = 0; i < 4; i++) m_res[i] = res[8*i +: 8];
    m_busy = 0; m_cmd_end = 1;
    checks++;
    if (cmd_end !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL completion: cmd_end=%b busy=%b required 1 0", cmd_end, busy);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    arst = 1'b1;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cmd_end !== 1'b0 || core_start !== 1'b0 || databus_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: busy=%b cmd_end=%b start=%b dout=%h required 0 0 0 00",
               busy, cmd_end, core_start, databus_out);
    end
    // Reset in the middle of a run, with a status read pending
    bus_write(9, 8'h00);
    repeat (3) @(negedge clk);
    cs = 1'b0; rd = 1'b0; addr = 4'hD; arst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cmd_end !== 1'b0 || core_start !== 1'b0 || databus_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_run: busy=%b cmd_end=%b start=%b dout=%h required 0 0 0 00",
               busy, cmd_end, core_start, databus_out);
    end
    arst = 1'b0; cs = 1'b1; rd = 1'b1;
    model_reset();
    @(negedge clk);
    core_done = 1'b1; core_result = 32'hDEADBEEF;
    @(negedge clk);
    core_done = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_end !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_after_reset: cmd_end=%b busy=%b required 0 0", cmd_end, busy);
    end
    bus_read(9, d);
    checks++;
    if (d !== m_read(9)) begin
      failures++;
      $display("FAIL result_after_reset: got %h required %h", d, m_read(9));
    end
  endtask

  task automatic test_write_read();
    logic [7:0] d;
    write_operands(32'h41000000, 32'h3ee839f1, OP_LOG2);
    for (int a = 0; a <= 8; a++) begin
      bus_read(a, d);
      checks++;
      if (d !== m_read(a)) begin
        failures++;
        $display("FAIL readback addr=%0h: got %h required %h", a, d, m_read(a));
      end
    end
    for (int r = 0; r < 3; r++) begin
      write_operands($urandom, $urandom, 8'($urandom_range(0, 6)));
      for (int a = 0; a <= 8; a++) begin
        bus_read(a, d);
        checks++;
        if (d !== m_read(a)) begin
          failures++;
          $display("FAIL rand_readback r=%0d addr=%0h: got %h required %h", r, a, d, m_read(a));
        end
      end
    end
    for (int a = 14; a <= 15; a++) begin
      bus_read(a, d);
      checks++;
      if (d !== 8'h00) begin
        failures++;
        $display("FAIL unmapped_read addr=%0h: got %h required 00", a, d);
      end
    end
  endtask

  task automatic test_start_complete();
    logic [7:0] d;
    write_operands(32'h41000000, 32'h3ee839f1, OP_LOG2);
    run_op(32'h40400000, 20, 1'b0, 1'b0);
    for (int a = 9; a <= 13; a++) begin
      bus_read(a, d);
      checks++;
      if (d !== m_read(a)) begin
        failures++;
        $display("FAIL result_read addr=%0h: got %h required %h", a, d, m_read(a));
      end
    end
    for (int r = 0; r < 4; r++) begin
      write_operands($urandom, $urandom, 8'($urandom_range(0, 6)));
      run_op($urandom, $urandom_range(2, 30), 1'b0, 1'b0);
      for (int a = 9; a <= 13; a++) begin
        bus_read(a, d);
        checks++;
        if (d !== m_read(a)) begin
          failures++;
          $display("FAIL rand_result r=%0d addr=%0h: got %h required %h", r, a, d, m_read(a));
        end
      end
    end
  endtask

  task automatic test_busy_protect();
    logic [7:0] d;
    logic [7:0] first;
    run_op($urandom, 10, 1'b1, 1'b0);
    bus_read(0, d);
    checks++;
    if (d !== m_read(0)) begin
      failures++;
      $display("FAIL busy_write_dropped: A0=%h required %h", d, m_read(0));
    end
    // Long wr pulse: only the first sampled cycle writes
    first = 8'($urandom);
    @(negedge clk); cs = 1'b0; wr = 1'b0; addr = 4'h0; databus_in = first;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); databus_in = ~first ^ 8'(i);
    end
    @(negedge clk); wr = 1'b1; cs = 1'b1;
    m_a[0] = first;
    bus_read(0, d);
    checks++;
    if (d !== m_read(0)) begin
      failures++;
      $display("FAIL long_wr_single: A0=%h required %h", d, m_read(0));
    end
  endtask

  task automatic test_handshake();
    logic [7:0] d;
    @(negedge clk); end_ack = 1'b1;
    @(negedge clk); end_ack = 1'b0;
    m_cmd_end = 0;
    checks++;
    if (cmd_end !== 1'b0) begin
      failures++;
      $display("FAIL end_ack_clear: cmd_end=%b required 0", cmd_end);
    end
    bus_read(13, d);
    checks++;
    if (d !== m_read(13)) begin
      failures++;
      $display("FAIL status_after_ack: got %h required %h", d, m_read(13));
    end
    run_op($urandom, 5, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (cmd_end !== 1'b1) begin
      failures++;
      $display("FAIL done_beats_ack: cmd_end=%b required 1", cmd_end);
    end
  endtask

  task automatic test_implicit_ack();
    logic [7:0] d;
    run_op($urandom, 7, 1'b0, 1'b0);
    @(negedge clk);
    core_done = 1'b1; core_result = ~m_word(m_res);
    @(negedge clk);
    core_done = 1'b0;
    checks++;
    if (cmd_end !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_done_ignored: cmd_end=%b busy=%b required 1 0", cmd_end, busy);
    end
    for (int a = 9; a <= 12; a++) begin
      bus_read(a, d);
      checks++;
      if (d !== m_read(a)) begin
        failures++;
        $display("FAIL idle_done_result addr=%0h: got %h required %h", a, d, m_read(a));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_start_complete();
    test_busy_protect();
    test_handshake();
    test_implicit_ack();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
